captura_tara: RTL and testbench
===============================

# captura_tara

Tare acquisition unit for the digital scale. On a tare-button press it averages a fixed number of raw weight samples from the load-cell path and latches the result as the tare value. The tare-subtraction stage downstream consumes that value: this block produces the tare, and that stage removes it. The block replaces the hard-wired tare constant with a measured, clearable one.

## Interface
Parameters:
- `WIDTH`, 16, sample and tare width (unsigned)
- `LOG2_N`, 3, log2 of samples averaged per capture (N = 8)
- `TARA_DEFAULT`, 50, tare value loaded at reset
- `TARA_MAX`, 1000, largest acceptable tare; larger averages are rejected

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `amostra`  in  WIDTH  raw weight sample, unsigned
- `amostra_valida`  in  1  one-cycle qualifier for `amostra`
- `botao_tara`  in  1  tare button level, already synchronised and debounced
- `limpar_tara`  in  1  one-cycle request to set the tare to 0
- `tara`  out  WIDTH  current tare value, registered
- `tara_atualizada`  out  1  one-cycle pulse when `tara` changes from a capture or a clear
- `ocupado`  out  1  high while a capture is in progress
- `erro_tara`  out  1  sticky flag: the last capture exceeded TARA_MAX

## Operation
- A rising edge of `botao_tara` (registered previous level) starts a capture. Edges while `ocupado` is high are ignored.
- FSM states: REPOUSO, ACUMULA, CALCULA.
- REPOUSO → ACUMULA on an edge:
  - clear the accumulator and the sample counter
  - set `ocupado`
- ACUMULA:
  - each cycle with `amostra_valida` adds `amostra` to the accumulator (WIDTH+LOG2_N bits, no overflow possible) and increments the counter
  - cycles without `amostra_valida` leave both unchanged
  - the N-th valid sample moves the FSM to CALCULA
- CALCULA (one cycle):
  - compute media = accumulator >> LOG2_N, truncating toward zero
  - if media ≤ TARA_MAX: `tara` ← media, pulse `tara_atualizada`, clear `erro_tara`
  - otherwise: `tara` unchanged, set `erro_tara`, no pulse
  - in both cases go to REPOUSO and clear `ocupado`
- `limpar_tara` in any state:
  - `tara` ← 0, pulse `tara_atualizada`, clear `erro_tara`
  - abort any capture: go to REPOUSO, clear `ocupado`, discard the accumulator
- Simultaneous `limpar_tara` and a button edge in REPOUSO: `limpar_tara` wins and no capture starts.
- `erro_tara` persists until the next successful capture or a `limpar_tara`.

## Timing
- Reset values:
  - `tara` = TARA_DEFAULT, `tara_atualizada` = 0, `ocupado` = 0, `erro_tara` = 0
  - FSM = REPOUSO, edge register = 0, accumulator and counter = 0
- A reset asserted mid-capture abandons the capture immediately and restores all reset values. No pulse is produced.
- Button edge seen at clock edge k: `ocupado` = 1 from k. A sample with `amostra_valida` in cycle k itself is not accumulated; accumulation starts at cycle k+1.
- N-th valid sample at edge m: CALCULA at m. `tara`, `tara_atualizada`, `erro_tara` update and `ocupado` falls at edge m+1.
- Minimum capture latency from button edge to new `tara` is N+2 cycles.
- `limpar_tara` at edge j: `tara` = 0 and `tara_atualizada` = 1 during cycle j+1.
- `tara` is stable between updates, so the downstream stage may sample it in any cycle.

## Structure
- Shared package `balanca_pkg`:
  - FSM state enum `estado_tara_t`
  - `TARA_DEFAULT` and `TARA_MAX` constants, also used by the tare-subtraction stage
  - `WIDTH_PESO` = 16
- Sub-module `detetor_flanco`: a one-register rising-edge detector, reusable for the other scale buttons.
- Accumulator, counter and FSM stay in `captura_tara`.

## Test plan
- Reset release → `tara` = 50, `erro_tara` = 0, `ocupado` = 0, no `tara_atualizada`.
- Button edge, then 8 valid samples of 120 on consecutive cycles → `tara` = 120 with a single `tara_atualizada` pulse 10 cycles after the edge.
- Button edge, samples 100..107 separated by random gaps with `amostra_valida` low → `tara` = 103 (828/8 truncated), `ocupado` high throughout.
- Button edge, 8 samples of 1200 → `tara` keeps its previous value, `erro_tara` = 1, no pulse. A later capture of 8 × 40 → `tara` = 40, `erro_tara` = 0.
- Button edge, 4 samples, then `limpar_tara` → `tara` = 0 and a pulse the next cycle, `ocupado` = 0. A second button edge during the first capture causes no restart.
- `rst_n` low after 5 samples of a capture → `tara` = 50, `ocupado` = 0. After release, 8 samples without a new button edge leave `tara` at 50.

Source files
------------

// File: rtl/balanca_pkg.sv
// Shared definitions for the scale datapath: tare FSM states and tare limits
// used by both the tare capture unit and the tare-subtraction stage.
package balanca_pkg;

  localparam int unsigned WIDTH_PESO   = 32'd16;
  localparam int unsigned TARA_DEFAULT = 32'd50;
  localparam int unsigned TARA_MAX     = 32'd1000;

  typedef enum logic [1:0] {
    REPOUSO = 2'd0,
    ACUMULA = 2'd1,
    CALCULA = 2'd2
  } estado_tara_t;

endpackage

// File: rtl/detetor_flanco.sv
// One-register rising-edge detector for already synchronised button levels.
module detetor_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic entrada,
  output logic flanco
);

  logic anterior_r;

  // Previous level of the input, used to spot a low-to-high transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anterior_r <= 1'b0;
    end else begin
      anterior_r <= entrada;
    end
  end

  // Combinational so the capture starts at the same clock edge that sees the press.
  assign flanco = entrada & ~anterior_r;

endmodule

// File: rtl/captura_tara.sv
// Tare acquisition: on a button press averages 2**LOG2_N raw samples and
// latches the mean as the tare value, rejecting means above TARA_MAX.
module captura_tara #(
  parameter int unsigned WIDTH        = balanca_pkg::WIDTH_PESO,
  parameter int unsigned LOG2_N       = 32'd3,
  parameter int unsigned TARA_DEFAULT = balanca_pkg::TARA_DEFAULT,
  parameter int unsigned TARA_MAX     = balanca_pkg::TARA_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] amostra,
  input  logic             amostra_valida,
  input  logic             botao_tara,
  input  logic             limpar_tara,
  output logic [WIDTH-1:0] tara,
  output logic             tara_atualizada,
  output logic             ocupado,
  output logic             erro_tara
);

  import balanca_pkg::*;

  localparam int unsigned ACC_W = WIDTH + LOG2_N;
  localparam int unsigned CNT_W = LOG2_N + 32'd1;

  localparam logic [CNT_W-1:0] CNT_ULTIMA   = CNT_W'((32'd1 << LOG2_N) - 32'd1);
  localparam logic [CNT_W-1:0] CNT_UM       = CNT_W'(32'd1);
  localparam logic [ACC_W-1:0] TARA_MAX_ACC = ACC_W'(TARA_MAX);
  localparam logic [WIDTH-1:0] TARA_RESET   = WIDTH'(TARA_DEFAULT);

  estado_tara_t     estado_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] tara_r;
  logic             tara_atualizada_r;
  logic             ocupado_r;
  logic             erro_tara_r;
  logic             flanco_s;
  logic [ACC_W-1:0] media_s;
  logic             media_ok_s;

  detetor_flanco u_flanco (
    .clk     (clk),
    .rst_n   (rst_n),
    .entrada (botao_tara),
    .flanco  (flanco_s)
  );

  // Mean of the accumulated samples and its range check against TARA_MAX.
  always_comb begin
    media_s    = acc_r >> LOG2_N;
    media_ok_s = (media_s <= TARA_MAX_ACC);
  end

  // Capture FSM with accumulator, sample counter and registered outputs; a clear beats everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r          <= REPOUSO;
      acc_r             <= {ACC_W{1'b0}};
      cnt_r             <= {CNT_W{1'b0}};
      tara_r            <= TARA_RESET;
      tara_atualizada_r <= 1'b0;
      ocupado_r         <= 1'b0;
      erro_tara_r       <= 1'b0;
    end else if (limpar_tara) begin
      estado_r          <= REPOUSO;
      acc_r             <= {ACC_W{1'b0}};
      cnt_r             <= {CNT_W{1'b0}};
      tara_r            <= {WIDTH{1'b0}};
      tara_atualizada_r <= 1'b1;
      ocupado_r         <= 1'b0;
      erro_tara_r       <= 1'b0;
    end else begin
      tara_atualizada_r <= 1'b0;
      case (estado_r)
        REPOUSO: begin
          if (flanco_s) begin
            estado_r  <= ACUMULA;
            acc_r     <= {ACC_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            ocupado_r <= 1'b1;
          end
        end
        ACUMULA: begin
          if (amostra_valida) begin
            acc_r <= acc_r + ACC_W'(amostra);
            cnt_r <= cnt_r + CNT_UM;
            if (cnt_r == CNT_ULTIMA) begin
              estado_r <= CALCULA;
            end
          end
        end
        CALCULA: begin
          // An out-of-range mean keeps the old tare and only raises the sticky error.
          if (media_ok_s) begin
            tara_r            <= media_s[WIDTH-1:0];
            tara_atualizada_r <= 1'b1;
            erro_tara_r       <= 1'b0;
          end else begin
            erro_tara_r <= 1'b1;
          end
          estado_r  <= REPOUSO;
          ocupado_r <= 1'b0;
        end
        default: begin
          estado_r  <= REPOUSO;
          ocupado_r <= 1'b0;
        end
      endcase
    end
  end

  assign tara            = tara_r;
  assign tara_atualizada = tara_atualizada_r;
  assign ocupado         = ocupado_r;
  assign erro_tara       = erro_tara_r;

endmodule

// File: tb/tb_captura_tara.sv
// Directed self-checking bench for captura_tara.
module tb_captura_tara;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] amostra = 16'd0;
  logic        amostra_valida = 1'b0;
  logic        botao_tara = 1'b0;
  logic        limpar_tara = 1'b0;
  logic [15:0] tara;
  logic        tara_atualizada;
  logic        ocupado;
  logic        erro_tara;

  int checks = 0;
  int errors = 0;

  captura_tara #(
    .WIDTH        (16),
    .LOG2_N       (3),
    .TARA_DEFAULT (50),
    .TARA_MAX     (1000)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .amostra         (amostra),
    .amostra_valida  (amostra_valida),
    .botao_tara      (botao_tara),
    .limpar_tara     (limpar_tara),
    .tara            (tara),
    .tara_atualizada (tara_atualizada),
    .ocupado         (ocupado),
    .erro_tara       (erro_tara)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_tara", 32'(tara), 32'd50);
    chk("reset_erro", 32'(erro_tara), 32'd0);
    chk("reset_ocupado", 32'(ocupado), 32'd0);
    chk("reset_pulso", 32'(tara_atualizada), 32'd0);

    // 8 x 120 back to back; sample in the edge cycle must be ignored
    botao_tara = 1'b1;
    amostra = 16'd5000;
    amostra_valida = 1'b1;
    tick();
    chk("c120_ocupado_k", 32'(ocupado), 32'd1);
    chk("c120_pulso_k", 32'(tara_atualizada), 32'd0);
    amostra = 16'd120;
    for (int i = 2; i <= 9; i++) begin
      tick();
      chk("c120_pulso_cedo", 32'(tara_atualizada), 32'd0);
      chk("c120_ocupado", 32'(ocupado), 32'd1);
    end
    amostra_valida = 1'b0;
    tick();
    chk("c120_pulso", 32'(tara_atualizada), 32'd1);
    chk("c120_tara", 32'(tara), 32'd120);
    chk("c120_ocupado_fim", 32'(ocupado), 32'd0);
    tick();
    chk("c120_pulso_unico", 32'(tara_atualizada), 32'd0);
    botao_tara = 1'b0;
    tick();

    // 100..107 with gaps -> 828/8 = 103
    botao_tara = 1'b1;
    tick();
    for (int s = 0; s < 8; s++) begin
      automatic int g = int'($urandom_range(0, 2));
      for (int j = 0; j < g; j++) begin
        amostra_valida = 1'b0;
        amostra = 16'd9999;
        tick();
        chk("gap_ocupado", 32'(ocupado), 32'd1);
      end
      amostra = 16'(100 + s);
      amostra_valida = 1'b1;
      tick();
      chk("gap_ocupado_amostra", 32'(ocupado), 32'd1);
    end
    amostra_valida = 1'b0;
    tick();
    chk("gap_tara", 32'(tara), 32'd103);
    chk("gap_pulso", 32'(tara_atualizada), 32'd1);
    chk("gap_ocupado_fim", 32'(ocupado), 32'd0);
    botao_tara = 1'b0;
    tick();

    // 8 x 1200 -> rejected, tara stays 103
    botao_tara = 1'b1;
    tick();
    amostra = 16'd1200;
    amostra_valida = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("max_sem_pulso", 32'(tara_atualizada), 32'd0);
    end
    amostra_valida = 1'b0;
    tick();
    chk("max_pulso", 32'(tara_atualizada), 32'd0);
    chk("max_tara", 32'(tara), 32'd103);
    chk("max_erro", 32'(erro_tara), 32'd1);
    chk("max_ocupado", 32'(ocupado), 32'd0);
    botao_tara = 1'b0;
    tick();
    chk("max_erro_fixo", 32'(erro_tara), 32'd1);

    // 8 x 40 clears the error
    botao_tara = 1'b1;
    tick();
    amostra = 16'd40;
    amostra_valida = 1'b1;
    repeat (8) tick();
    amostra_valida = 1'b0;
    tick();
    chk("c40_tara", 32'(tara), 32'd40);
    chk("c40_erro", 32'(erro_tara), 32'd0);
    chk("c40_pulso", 32'(tara_atualizada), 32'd1);
    botao_tara = 1'b0;
    tick();

    // Second edge mid-capture must not restart the count
    botao_tara = 1'b1;
    tick();
    amostra = 16'd200;
    amostra_valida = 1'b1;
    tick();
    tick();
    botao_tara = 1'b0;
    tick();
    botao_tara = 1'b1;
    tick();
    chk("rearm_ocupado", 32'(ocupado), 32'd1);
    repeat (4) tick();
    amostra_valida = 1'b0;
    tick();
    chk("rearm_tara", 32'(tara), 32'd200);
    chk("rearm_pulso", 32'(tara_atualizada), 32'd1);
    chk("rearm_ocupado_fim", 32'(ocupado), 32'd0);
    botao_tara = 1'b0;
    tick();

    // Clear after 4 samples aborts the capture
    botao_tara = 1'b1;
    tick();
    amostra = 16'd77;
    amostra_valida = 1'b1;
    repeat (4) tick();
    amostra_valida = 1'b0;
    limpar_tara = 1'b1;
    tick();
    limpar_tara = 1'b0;
    chk("limpar_tara", 32'(tara), 32'd0);
    chk("limpar_pulso", 32'(tara_atualizada), 32'd1);
    chk("limpar_ocupado", 32'(ocupado), 32'd0);
    tick();
    chk("limpar_pulso_unico", 32'(tara_atualizada), 32'd0);
    amostra_valida = 1'b1;
    repeat (6) tick();
    amostra_valida = 1'b0;
    tick();
    chk("limpar_abortado", 32'(tara), 32'd0);
    chk("limpar_abortado_ocupado", 32'(ocupado), 32'd0);
    botao_tara = 1'b0;
    tick();

    // Clear and edge together in REPOUSO: clear wins, no capture
    botao_tara = 1'b1;
    limpar_tara = 1'b1;
    tick();
    limpar_tara = 1'b0;
    chk("simult_ocupado", 32'(ocupado), 32'd0);
    chk("simult_pulso", 32'(tara_atualizada), 32'd1);
    amostra = 16'd500;
    amostra_valida = 1'b1;
    repeat (8) tick();
    amostra_valida = 1'b0;
    tick();
    chk("simult_tara", 32'(tara), 32'd0);
    chk("simult_ocupado_fim", 32'(ocupado), 32'd0);
    botao_tara = 1'b0;
    tick();

    // Reset after 5 samples abandons the capture
    botao_tara = 1'b1;
    tick();
    amostra = 16'd300;
    amostra_valida = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    botao_tara = 1'b0;
    amostra_valida = 1'b0;
    #1;
    chk("rst_tara", 32'(tara), 32'd50);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_pulso", 32'(tara_atualizada), 32'd0);
    tick();
    rst_n = 1'b1;
    amostra_valida = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rst_sem_pulso", 32'(tara_atualizada), 32'd0);
    end
    amostra_valida = 1'b0;
    tick();
    tick();
    chk("rst_tara_fim", 32'(tara), 32'd50);
    chk("rst_ocupado_fim", 32'(ocupado), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
